// File: rtl/uart_baud_gen.sv
// Oversampling baud generator: sub-sample ticks at OSR x baud, phase tracking, vote/bit-end strobes.
// Define UART_BAUD_FRAC_EN to include the fractional accumulator that stretches periods on carry.
module uart_baud_gen #(
  parameter int OSR    = 16,
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int PH_W   = $clog2(OSR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  output logic              tick,
  output logic [PH_W-1:0]   phase,
  output logic              vote_early,
  output logic              vote_mid,
  output logic              vote_late,
  output logic              bit_end
);

  localparam int CNT_W = DIV_W + 1;

  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0] PH_EARLY = PH_W'(OSR / 2 - 3);
  localparam logic [PH_W-1:0] PH_MID   = PH_W'(OSR / 2 - 1);
  localparam logic [PH_W-1:0] PH_LATE  = PH_W'(OSR / 2 + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             carry;
  logic             cnt_zero;
  logic             tick_int;

  // Strobe semantics: every output strobe is a single-cycle pulse, high only in
  // a cycle where tick is high; consumers sample it on the same clock edge.
  assign cnt_zero = (cnt_q == '0);
  assign tick_int = rst_n & en & ~clear & cnt_zero;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    carry = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (tick_int) begin
      {carry, acc_d} = {1'b0, acc_q} + {1'b0, cfg_div_frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  logic frac_unused;
  assign frac_unused = ^cfg_div_frac;
  assign carry       = 1'b0;
`endif

  // The carry stretches the period that begins at this reload by one cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CNT_W'(cfg_div_int);
    end else if (tick_int) begin
      cnt_d = CNT_W'(cfg_div_int) + CNT_W'(carry);
    end else if (en && !cnt_zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (tick_int) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign tick       = tick_int;
  assign phase      = phase_q;
  assign vote_early = tick_int & (phase_q == PH_EARLY);
  assign vote_mid   = tick_int & (phase_q == PH_MID);
  assign vote_late  = tick_int & (phase_q == PH_LATE);
  assign bit_end    = tick_int & (phase_q == PH_LAST);

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: directed scenarios push expected strobe events,
// monitors pop and compare them whenever a DUT presents a tick or strobe.
module tb_uart_baud_gen;

`ifdef UART_BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en16, clr16, en8, clr8;
  logic [15:0] cfg_int;
  logic [3:0]  cfg_frac;

  logic        tick16, ve16, vm16, vl16, be16;
  logic [3:0]  phase16;
  logic        tick8, ve8, vm8, vl8, be8;
  logic [2:0]  phase8;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] exp16_q[$];
  logic [31:0] exp8_q[$];

  uart_baud_gen #(.OSR(16), .DIV_W(16), .FRAC_W(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .en(en16), .clear(clr16),
    .cfg_div_int(cfg_int), .cfg_div_frac(cfg_frac),
    .tick(tick16), .phase(phase16), .vote_early(ve16), .vote_mid(vm16),
    .vote_late(vl16), .bit_end(be16)
  );

  uart_baud_gen #(.OSR(8), .DIV_W(16), .FRAC_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .clear(clr8),
    .cfg_div_int(cfg_int), .cfg_div_frac(cfg_frac),
    .tick(tick8), .phase(phase8), .vote_early(ve8), .vote_mid(vm8),
    .vote_late(vl8), .bit_end(be8)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // event encoding: {cycle, phase, vote_early, vote_mid, vote_late, bit_end}
  function automatic logic [31:0] pack(input int c, input int ph,
                                       input logic ve, input logic vm,
                                       input logic vl, input logic be);
    return {c[21:0], ph[5:0], ve, vm, vl, be};
  endfunction

  // OSR=16: votes at phases 5/7/9, bit_end at 15
  function automatic void push16(input int c, input int ph);
    exp16_q.push_back(pack(c, ph, ph == 5, ph == 7, ph == 9, ph == 15));
  endfunction

  // OSR=8: votes at phases 1/3/5, bit_end at 7
  function automatic void push8(input int c, input int ph);
    exp8_q.push_back(pack(c, ph, ph == 1, ph == 3, ph == 5, ph == 7));
  endfunction

  // scoreboard monitors
  initial begin : mon16
    logic [31:0] a, e;
    forever begin
      @(negedge clk);
      if (tick16 | ve16 | vm16 | vl16 | be16) begin
        a = pack(cyc, int'(phase16), ve16, vm16, vl16, be16);
        n_tests++;
        if (exp16_q.size() == 0) begin
          n_fail++;
          $display("FAIL mon16_unexpected: got cyc %0d phase %0d strobes %b, required no strobe",
                   a[31:10], a[9:4], a[3:0]);
        end else begin
          e = exp16_q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL mon16_event: got cyc %0d phase %0d strobes %b, required cyc %0d phase %0d strobes %b",
                     a[31:10], a[9:4], a[3:0], e[31:10], e[9:4], e[3:0]);
          end
        end
      end
    end
  end

  initial begin : mon8
    logic [31:0] a, e;
    forever begin
      @(negedge clk);
      if (tick8 | ve8 | vm8 | vl8 | be8) begin
        a = pack(cyc, int'(phase8), ve8, vm8, vl8, be8);
        n_tests++;
        if (exp8_q.size() == 0) begin
          n_fail++;
          $display("FAIL mon8_unexpected: got cyc %0d phase %0d strobes %b, required no strobe",
                   a[31:10], a[9:4], a[3:0]);
        end else begin
          e = exp8_q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL mon8_event: got cyc %0d phase %0d strobes %b, required cyc %0d phase %0d strobes %b",
                     a[31:10], a[9:4], a[3:0], e[31:10], e[9:4], e[3:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear16();
    clr16 = 1'b1;
    en16  = 1'b1;
    @(posedge clk);
    #1;
    clr16 = 1'b0;
  endtask

  task automatic pulse_clear8();
    clr8 = 1'b1;
    en8  = 1'b1;
    @(posedge clk);
    #1;
    clr8 = 1'b0;
  endtask

  task automatic drain(input string name);
    @(posedge clk);
    #1;
    n_tests++;
    if (exp16_q.size() != 0 || exp8_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_ticks: got %0d/%0d events still pending, required 0/0",
               name, exp16_q.size(), exp8_q.size());
    end
    exp16_q.delete();
    exp8_q.delete();
  endtask

  initial begin : main
    int c0, c1, t, t17;
    en16 = 1'b0; clr16 = 1'b0; en8 = 1'b0; clr8 = 1'b0;
    cfg_int = 16'd3; cfg_frac = 4'd0; rst_n = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tick16", int'(tick16), 0);
    check("rst_phase16", int'(phase16), 0);
    check("rst_strobes16", int'({ve16, vm16, vl16, be16}), 0);
    check("rst_tick8", int'(tick8), 0);
    check("rst_phase8", int'(phase8), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // div 3, no fraction: tick every 4 cycles, 64-cycle bit, contiguous next bit
    cfg_int = 16'd3; cfg_frac = 4'd0;
    c0 = cyc;
    for (int k = 1; k <= 17; k++) push16(c0 + 4 * k, (k - 1) % 16);
    pulse_clear16();
    wait_cyc(c0 + 69);
    en16 = 1'b0;
    check("t1_phase_after_bit", int'(phase16), 1);
    drain("t1");

    // fraction 8/16: periods 4,5,4,5.. with accumulator, all 4 without
    cfg_frac = 4'd8;
    c0 = cyc;
    t = c0 + 4;
    t17 = 0;
    for (int k = 1; k <= 17; k++) begin
      push16(t, (k - 1) % 16);
      if (k == 17) t17 = t;
      t = t + 4 + ((FRAC_ON && (k % 2 == 0)) ? 1 : 0);
    end
    pulse_clear16();
    wait_cyc(t17 + 1);
    en16 = 1'b0;
    drain("t2");
    cfg_frac = 4'd0;

    // enable dropped for 10 cycles at phase 5 with cnt 2
    c0 = cyc;
    for (int k = 1; k <= 5; k++) push16(c0 + 4 * k, k - 1);
    push16(c0 + 34, 5);
    push16(c0 + 38, 6);
    pulse_clear16();
    wait_cyc(c0 + 22);
    en16 = 1'b0;
    wait_cyc(c0 + 27);
    check("t3_phase_frozen", int'(phase16), 5);
    check("t3_tick_frozen", int'(tick16), 0);
    wait_cyc(c0 + 32);
    en16 = 1'b1;
    wait_cyc(c0 + 39);
    en16 = 1'b0;
    drain("t3");

    // clear in the same cycle as the phase-15 tick
    c0 = cyc;
    for (int k = 1; k <= 15; k++) push16(c0 + 4 * k, k - 1);
    c1 = c0 + 64;
    push16(c1 + 4, 0);
    push16(c1 + 8, 1);
    pulse_clear16();
    wait_cyc(c1);
    clr16 = 1'b1;
    #1;
    check("t4_clear_no_tick", int'(tick16), 0);
    check("t4_clear_no_bit_end", int'(be16), 0);
    @(posedge clk);
    #1;
    clr16 = 1'b0;
    check("t4_phase_after_clear", int'(phase16), 0);
    wait_cyc(c1 + 9);
    en16 = 1'b0;
    drain("t4");

    // divider changed mid-period: applies from the next reload only
    cfg_int = 16'd3;
    c0 = cyc;
    push16(c0 + 4, 0);
    push16(c0 + 8, 1);
    push16(c0 + 10, 2);
    push16(c0 + 12, 3);
    pulse_clear16();
    wait_cyc(c0 + 6);
    cfg_int = 16'd1;
    wait_cyc(c0 + 13);
    en16 = 1'b0;
    drain("t6");
    cfg_int = 16'd3;

    // OSR=8, div 0: tick every cycle, votes 1/3/5, bit_end 7, wrap
    cfg_int = 16'd0;
    c0 = cyc;
    for (int k = 1; k <= 10; k++) push8(c0 + k, (k - 1) % 8);
    pulse_clear8();
    wait_cyc(c0 + 11);
    en8 = 1'b0;
    check("t5_phase8_after_wrap", int'(phase8), 2);
    drain("t5");
    cfg_int = 16'd3;

    // asynchronous reset mid-period, then release without clear
    c0 = cyc;
    push16(c0 + 4, 0);
    push16(c0 + 10, 0);
    push16(c0 + 14, 1);
    pulse_clear16();
    wait_cyc(c0 + 8);
    rst_n = 1'b0;
    #1;
    check("t7_rst_tick", int'(tick16), 0);
    check("t7_rst_phase", int'(phase16), 0);
    check("t7_rst_bit_end", int'(be16), 0);
    wait_cyc(c0 + 10);
    rst_n = 1'b1;
    #1;
    check("t7_first_tick_after_rst", int'(tick16), 1);
    wait_cyc(c0 + 15);
    en16 = 1'b0;
    drain("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
